// File: rtl/frac_baud_generator.sv
// Fractional baud-rate generator.
// Produces a baud clock whose average period is (div_int + div_frac/2^FRAC_W) i_clk cycles.
// A FRAC_W-bit accumulator stretches individual periods by one cycle on carry-out. The
// divisor is updated through a strobe. Updates made while running are held until the
// current period ends, so a period is never cut short or stretched.
//
// Ports:
//   i_clk          system clock, rising-edge
//   i_rst          asynchronous active-high reset
//   i_enable       run enable; low forces idle, configuration retained
//   i_div_int      integer divisor (must be >= 4)
//   i_div_frac     fractional divisor, units of 1/2^FRAC_W cycle
//   i_update_baud  strobe capturing i_div_int / i_div_frac
//   o_clk          baud clock, high for c in 0..N/2
//   o_rising_edge  pulse at c == 0
//   o_stable       pulse at c == N/4 (sample point)
//   o_falling_edge pulse at c == N/2 (last high cycle)
//   o_active       high while running
//   o_cfg_err      pulse the cycle after a rejected update
module frac_baud_generator #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_update_baud,
  output logic              o_clk,
  output logic              o_rising_edge,
  output logic              o_stable,
  output logic              o_falling_edge,
  output logic              o_active,
  output logic              o_cfg_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic [DIV_W-1:0]    act_int_q, act_int_d;
  logic [FRAC_W-1:0]   act_frac_q, act_frac_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                pend_q, pend_d;
  logic [DIV_W-1:0]    pend_int_q, pend_int_d;
  logic [FRAC_W-1:0]   pend_frac_q, pend_frac_d;

  logic clk_q, clk_d, rise_q, rise_d, stable_q, stable_d;
  logic fall_q, fall_d, active_q, active_d, err_q, err_d;

  logic              upd_ok;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W-1:0]  last_cnt;
  logic [DIV_W-1:0]  half_d, quarter_d;
  logic              run_d;

  assign upd_ok  = i_update_baud && (i_div_int >= DIV_W'(4));
  // Carry out of acc + F lengthens the current period by one cycle.
  assign acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
  assign last_cnt = act_int_q - DIV_W'(1) + {{(DIV_W-1){1'b0}}, acc_sum[FRAC_W]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    cfg_valid_d = cfg_valid_q;
    pend_d      = pend_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    err_d       = i_update_baud && !upd_ok;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        acc_d = '0;
        if (upd_ok) begin
          act_int_d   = i_div_int;
          act_frac_d  = i_div_frac;
          cfg_valid_d = 1'b1;
          pend_d      = 1'b0;
        end
        if (i_enable && (upd_ok || cfg_valid_q)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!i_enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          acc_d   = '0;
          pend_d  = 1'b0;
          // Fold any outstanding update into the retained configuration.
          if (upd_ok) begin
            act_int_d  = i_div_int;
            act_frac_d = i_div_frac;
          end else if (pend_q) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
          end
        end else if (cnt_q == last_cnt) begin
          cnt_d = '0;
          if (upd_ok) begin
            // Strobe on the final cycle governs the very next period.
            act_int_d  = i_div_int;
            act_frac_d = i_div_frac;
            acc_d      = '0;
            pend_d     = 1'b0;
          end else if (pend_q) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
            acc_d      = '0;
            pend_d     = 1'b0;
          end else begin
            acc_d = acc_sum[FRAC_W-1:0];
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (upd_ok) begin
            pend_d      = 1'b1;
            pend_int_d  = i_div_int;
            pend_frac_d = i_div_frac;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered: decode them from the next-state values.
    run_d     = (state_d == StRun);
    half_d    = act_int_d >> 1;
    quarter_d = act_int_d >> 2;
    clk_d     = run_d && (cnt_d <= half_d);
    rise_d    = run_d && (cnt_d == '0);
    stable_d  = run_d && (cnt_d == quarter_d);
    fall_d    = run_d && (cnt_d == half_d);
    active_d  = run_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      act_int_q   <= '0;
      act_frac_q  <= '0;
      cfg_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      clk_q       <= 1'b0;
      rise_q      <= 1'b0;
      stable_q    <= 1'b0;
      fall_q      <= 1'b0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      cfg_valid_q <= cfg_valid_d;
      pend_q      <= pend_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      clk_q       <= clk_d;
      rise_q      <= rise_d;
      stable_q    <= stable_d;
      fall_q      <= fall_d;
      active_q    <= active_d;
      err_q       <= err_d;
    end
  end

  assign o_clk          = clk_q;
  assign o_rising_edge  = rise_q;
  assign o_stable       = stable_q;
  assign o_falling_edge = fall_q;
  assign o_active       = active_q;
  assign o_cfg_err      = err_q;

endmodule

// File: doc/frac_baud_generator.md
FRAC_BAUD_GENERATOR -- requirements
Module: frac_baud_generator

Interface
REQ-001 Parameter DIV_W, default 16: width of the integer divisor, in i_clk cycles per baud period.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor, in units of 1/2^FRAC_W cycle.
REQ-003 Port i_clk, input, 1 bit: the single system clock; all logic SHALL be rising-edge triggered on it.
REQ-004 Port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port i_enable, input, 1 bit: generator run enable.
REQ-006 Port i_div_int, input, DIV_W bits: requested integer divisor.
REQ-007 Port i_div_frac, input, FRAC_W bits: requested fractional divisor.
REQ-008 Port i_update_baud, input, 1 bit: single-cycle strobe that captures i_div_int and i_div_frac.
REQ-009 Port o_clk, output, 1 bit: baud clock.
REQ-010 Port o_rising_edge, output, 1 bit: one-cycle pulse in the first cycle of each baud period.
REQ-011 Port o_stable, output, 1 bit: one-cycle pulse at the quarter-period point (data sample point).
REQ-012 Port o_falling_edge, output, 1 bit: one-cycle pulse in the last high cycle of o_clk.
REQ-013 Port o_active, output, 1 bit: high while a valid configuration is running.
REQ-014 Port o_cfg_err, output, 1 bit: one-cycle pulse when an update is rejected.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States SHALL be IDLE (no valid configuration, or i_enable low) and RUN.
- In IDLE, all outputs SHALL be 0 and the period counter c SHALL be 0.
REQ-017 In RUN, c SHALL count 0..P-1 and then wrap to 0, where P is the current period length.
- Let N be the active integer divisor.
- o_clk SHALL be 1 for c in 0..N/2 (integer divide) and 0 for all other c.
REQ-018 o_rising_edge SHALL be 1 exactly when c==0, o_stable exactly when c==N/4, and o_falling_edge exactly when c==N/2.
- o_clk SHALL be 1 in all three of those cycles.
REQ-019 Fractional rate:
- A FRAC_W-bit accumulator acc SHALL add the active fractional divisor F at each period wrap.
- The next P SHALL be N+1 if that add carries out, else N.
- acc SHALL clear to 0 whenever a configuration is applied.
- Over 2^FRAC_W periods the total SHALL be exactly N*2^FRAC_W+F cycles.
REQ-020 An update is valid only if i_div_int >= 4.
- An update with i_div_int < 4 SHALL be discarded and o_cfg_err SHALL pulse in the next cycle.
- The active and pending configurations SHALL be unchanged by a rejected update.
REQ-021 A valid update in IDLE, with i_enable=1, SHALL apply immediately.
- The cycle after the strobe SHALL be c==0, with o_rising_edge=1, o_clk=1 and o_active=1.
REQ-022 A valid update in RUN SHALL be held in a pending register.
- It SHALL be applied at the next wrap, so the first new-rate period starts with o_rising_edge.
- The current period SHALL never be truncated or stretched by an update.
REQ-023 Update strobe in the same cycle as c==P-1: the new configuration SHALL govern the immediately following period.
REQ-024 A second valid update while one is pending SHALL overwrite the pending value; only the last one SHALL be applied.
REQ-025 i_enable low SHALL force IDLE on the next edge; the configuration SHALL be retained.
- On i_enable rising, with a valid configuration, RUN SHALL restart at c==0 in the next cycle with acc=0.
REQ-026 A valid update while i_enable is low SHALL become the active configuration directly, without starting the generator.

Reset
REQ-027 i_rst high SHALL immediately, without waiting for i_clk, clear:
- all outputs to 0;
- c, acc and the pending flag to 0;
- the configuration-valid flag to 0.
REQ-028 After i_rst deasserts, the block SHALL stay in IDLE with outputs 0 until a valid update is received.
REQ-029 Reset asserted mid-period SHALL abort that period with no further edge pulses.

Verification (DIV_W=16, FRAC_W=4)
REQ-030 Reset for 16 cycles, then release -> all outputs 0 and o_active=0 for 20 following cycles.
REQ-031 Update with int=8, frac=0, enable=1 -> period 8 cycles, repeated over 10 periods:
- o_clk high at c0-c4 and low at c5-c7;
- o_rising_edge at c0, o_stable at c2, o_falling_edge at c4.
REQ-032 Update with int=8, frac=8 -> periods alternate 8,9,8,9...; 16 periods total exactly 136 cycles.
REQ-033 Running int=8, then strobe int=12 at c==3 -> the current period still ends at c7, and the next period is 12 cycles with o_stable at c3 and o_falling_edge at c6.
REQ-034 Strobe int=3 -> o_cfg_err=1 for exactly one cycle; running period stays 8.
REQ-035 Running int=8, assert i_rst at c==2 -> outputs 0 before the next i_clk edge, with no pulses after release until a new update is sent.
